trisc_ctrl_fsm: RTL and testbench
=================================

# trisc_ctrl_fsm

Parametrised control unit for the TRISC datapath. It sequences fetch, decode and execute and drives the datapath control word. Compared with the fixed-opcode controller, it adds:
- an encoded opcode input of configurable width,
- a memory ready handshake with watchdog,
- run/halt control at instruction boundaries,
- HLT and optional JZ instructions,
- an illegal-opcode trap.

It sits between the instruction/memory-data path and the PC, MAR, ACC and ALU-buffer registers.

## Interface
Parameters:
- OPW, 4, opcode field width; must be ≥ 3; opcodes ≥ 8 are illegal.
- WAIT_MAX, 15, maximum consecutive cycles mem_ready may stay low in a memory state. 0 disables the watchdog.

Ports:
- SysClock  in  1  clock. All state changes occur on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- run  in  1  level; 1 permits execution.
- opcode  in  OPW  memory data-out upper field; valid in DECODE.
- acc_zero  in  1  ACC == 0 flag.
- mem_ready  in  1  memory access complete this cycle.
- ctrl  out  15  control word C0..C14. Bit 6 is reserved and always 0.
- mem_req  out  1  memory access requested.
- halted  out  1  in HALT or TRAP.
- err  out  1  sticky; set in TRAP.

## Operation
Control bits:
- C0: datapath clear
- C1: PC load
- C2: PC increment
- C3: address select PC (0 selects MDO)
- C4: MAR load
- C5: memory write
- C7: IR load
- C8: ACC clear
- C9: ACC increment
- C10: ACC source MDO (0 selects ALU)
- C11: ACC load
- C12, C13: ALU op (00 = ADD)
- C14: ALU buffer load

Opcodes: INC=0, CLR=1, JMP=2, LDA=3, STA=4, ADD=5, HLT=6, JZ=7.

States. Outputs are Moore; unlisted ctrl bits are 0.
- IDLE: ctrl=0. Goes to INIT when run=1.
- INIT: C0. Goes to F_ADDR.
- F_ADDR: C3, C4. Goes to IDLE if run=0, else to F_MEM.
- F_MEM: C3, C4, mem_req. Holds until mem_ready, then goes to DECODE.
- DECODE: C2, C7. Dispatches on opcode:
  - INC → X_INC (C9)
  - CLR → X_CLR (C8)
  - JMP → X_JMP (C1)
  - JZ → X_JZ (C1 only if acc_zero)
  - HLT → HALT
  - LDA → L_ADDR
  - STA → S_ADDR
  - ADD → A_ADDR
  - any other opcode → TRAP
  - X_INC, X_CLR, X_JMP and X_JZ each go to F_ADDR.
- Load sequence:
  - L_ADDR: C4. Goes to L_MEM.
  - L_MEM: C4, mem_req. Holds until mem_ready, then goes to L_LOAD.
  - L_LOAD: C10, C11. Goes to F_ADDR.
- Store sequence:
  - S_ADDR: C4. Goes to S_WR.
  - S_WR: C4, C5, mem_req. Holds until mem_ready, then goes to F_ADDR.
- Add sequence:
  - A_ADDR: C4. Goes to A_MEM.
  - A_MEM: C4, mem_req. Holds until mem_ready, then goes to A_BUF.
  - A_BUF: C14. Goes to A_ACC.
  - A_ACC: C11 (C10=0, C12/C13=00). Goes to F_ADDR.
- HALT: halted=1, ctrl=0. Goes to IDLE when run=0.
- TRAP: halted=1, err=1, ctrl=0. Left only by Reset.
- Unused state encodings go to TRAP.

Watchdog:
- A counter clears on entry to any mem_req state and increments each cycle mem_ready=0.
- When it reaches WAIT_MAX with mem_ready still 0, the next state is TRAP.
- mem_ready=1 on the WAIT_MAX-th cycle still completes the access.

## Timing
- Reset: state=IDLE; ctrl=0, mem_req=0, halted=0, err=0; watchdog counter=0.
- Reset asserted mid-instruction aborts it immediately. No write completes after Reset assertion.
- Cycles per instruction with mem_ready tied high, counted from F_ADDR back to F_ADDR:
  - INC, CLR, JMP, JZ: 4
  - STA: 5
  - LDA: 6
  - ADD: 7
- Each low cycle of mem_ready adds one cycle.
- run is sampled only in IDLE, F_ADDR and HALT. Dropping run mid-instruction completes that instruction.
- HALT with run held at 1 stays in HALT. Re-running requires run 1→0→1, which passes through INIT (C0 pulse).

## Configuration
- TRISC_JZ_EN defined: opcode 7 = JZ as described above.
- TRISC_JZ_EN undefined: opcode 7 is illegal and goes to TRAP. The acc_zero input is unused.

## Structure
- Package trisc_pkg holds:
  - opcode constants,
  - state encoding localparams (5 bits),
  - ctrl bit-index constants,
  - the CW=15 width constant.
- Sub-module trisc_op_decode: combinational opcode + acc_zero → dispatch state and illegal flag. It contains the TRISC_JZ_EN branch.
- The FSM and watchdog counter stay in the top module.

## Test plan
- Reset, run=1, mem_ready=1, opcode=INC:
  - INIT asserts C0 for 1 cycle.
  - C9 pulses every 4 cycles.
- opcode=ADD, mem_ready low for 3 cycles in A_MEM:
  - mem_req is held for 4 cycles.
  - C14, then C11 with C10=0.
  - Total 10 cycles.
- opcode=JZ:
  - acc_zero=1 → C1 pulses once.
  - acc_zero=0 → ctrl=0 in the execute cycle.
  - Without TRISC_JZ_EN → TRAP, err=1.
- opcode=HLT, then opcode=12:
  - HLT: halted=1 and stays until run=0, then IDLE.
  - Opcode 12: TRAP, err=1, which only Reset clears.
- WAIT_MAX=15, mem_ready held 0 in S_WR:
  - TRAP after 15 cycles.
  - Same test with mem_ready=1 on cycle 15: completes, no error.
- Reset asserted during S_WR:
  - Outputs go to 0 asynchronously (C5=0 immediately).
  - State=IDLE.

Source files
------------

// File: rtl/trisc_pkg.sv
// Shared constants for the TRISC controller: opcodes, state encoding,
// control-word bit positions and control-word width.
package trisc_pkg;

  localparam int CW = 15;
  localparam int SW = 5;

  // Opcode values (low three bits of the opcode field)
  localparam logic [2:0] OP_INC = 3'd0;
  localparam logic [2:0] OP_CLR = 3'd1;
  localparam logic [2:0] OP_JMP = 3'd2;
  localparam logic [2:0] OP_LDA = 3'd3;
  localparam logic [2:0] OP_STA = 3'd4;
  localparam logic [2:0] OP_ADD = 3'd5;
  localparam logic [2:0] OP_HLT = 3'd6;
  localparam logic [2:0] OP_JZ  = 3'd7;

  // Control word bit positions; bit 6 is reserved
  localparam int C_CLR     = 0;
  localparam int C_PC_LD   = 1;
  localparam int C_PC_INC  = 2;
  localparam int C_ADDR_PC = 3;
  localparam int C_MAR_LD  = 4;
  localparam int C_MEM_WR  = 5;
  localparam int C_IR_LD   = 7;
  localparam int C_ACC_CLR = 8;
  localparam int C_ACC_INC = 9;
  localparam int C_ACC_MDO = 10;
  localparam int C_ACC_LD  = 11;
  localparam int C_ALU0    = 12;
  localparam int C_ALU1    = 13;
  localparam int C_BUF_LD  = 14;

  typedef enum logic [SW-1:0] {
    ST_IDLE   = 5'd0,
    ST_INIT   = 5'd1,
    ST_F_ADDR = 5'd2,
    ST_F_MEM  = 5'd3,
    ST_DECODE = 5'd4,
    ST_X_INC  = 5'd5,
    ST_X_CLR  = 5'd6,
    ST_X_JMP  = 5'd7,
    ST_X_JZ   = 5'd8,
    ST_HALT   = 5'd9,
    ST_L_ADDR = 5'd10,
    ST_L_MEM  = 5'd11,
    ST_L_LOAD = 5'd12,
    ST_S_ADDR = 5'd13,
    ST_S_WR   = 5'd14,
    ST_A_ADDR = 5'd15,
    ST_A_MEM  = 5'd16,
    ST_A_BUF  = 5'd17,
    ST_A_ACC  = 5'd18,
    ST_TRAP   = 5'd19
  } state_t;

endpackage

// File: rtl/trisc_op_decode.sv
// Opcode dispatch for the TRISC controller: maps opcode (+ acc_zero) to the
// first execute state and flags illegal opcodes.
// Build option: TRISC_JZ_EN enables opcode 7 as JZ; otherwise opcode 7 traps.
module trisc_op_decode
  import trisc_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic [OPW-1:0] opcode_i,
  input  logic           acc_zero_i,
  output state_t         dispatch_o,
  output logic           illegal_o
);

`ifndef TRISC_JZ_EN
  logic unused_acc_zero;
  assign unused_acc_zero = acc_zero_i;
`endif

  // Any opcode with bits above the low three set is illegal.
  always_comb begin
    dispatch_o = ST_TRAP;
    illegal_o  = 1'b1;
    if ((opcode_i >> 3) == '0) begin
      illegal_o = 1'b0;
      case (opcode_i[2:0])
        OP_INC:  dispatch_o = ST_X_INC;
        OP_CLR:  dispatch_o = ST_X_CLR;
        OP_JMP:  dispatch_o = ST_X_JMP;
        OP_LDA:  dispatch_o = ST_L_ADDR;
        OP_STA:  dispatch_o = ST_S_ADDR;
        OP_ADD:  dispatch_o = ST_A_ADDR;
        OP_HLT:  dispatch_o = ST_HALT;
`ifdef TRISC_JZ_EN
        // Taken JZ reuses the JMP execute state; not-taken idles one cycle.
        OP_JZ:   dispatch_o = acc_zero_i ? ST_X_JMP : ST_X_JZ;
`else
        OP_JZ: begin
          dispatch_o = ST_TRAP;
          illegal_o  = 1'b1;
        end
`endif
        default: begin
          dispatch_o = ST_TRAP;
          illegal_o  = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/trisc_ctrl_fsm.sv
// TRISC control unit: fetch/decode/execute sequencer with Moore control word,
// memory-ready handshake with watchdog, run/halt control and illegal trap.
// Build option: TRISC_JZ_EN (handled in trisc_op_decode) enables JZ.
module trisc_ctrl_fsm
  import trisc_pkg::*;
#(
  parameter int OPW      = 4,
  parameter int WAIT_MAX = 15
) (
  input  logic           SysClock,
  input  logic           Reset,
  input  logic           run,
  input  logic [OPW-1:0] opcode,
  input  logic           acc_zero,
  input  logic           mem_ready,
  output logic [CW-1:0]  ctrl,
  output logic           mem_req,
  output logic           halted,
  output logic           err
);

  localparam int WDW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);

  state_t         state_q, state_d;
  logic [WDW-1:0] wd_q, wd_d;
  state_t         op_dispatch;
  logic           op_illegal;
  logic           wd_fire;

  trisc_op_decode #(.OPW(OPW)) u_dec (
    .opcode_i   (opcode),
    .acc_zero_i (acc_zero),
    .dispatch_o (op_dispatch),
    .illegal_o  (op_illegal)
  );

  // Counter holds WAIT_MAX-1 on the WAIT_MAX-th low cycle; a low ready then traps.
  assign wd_fire = (WAIT_MAX != 0) && (wd_q == WD_LAST);

  // State and watchdog registers; reset aborts any access immediately.
  always_ff @(posedge SysClock or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
    end
  end

  // Next state, Moore outputs and watchdog update.
  always_comb begin
    state_d = state_q;
    wd_d    = '0;
    ctrl    = '0;
    mem_req = 1'b0;
    halted  = 1'b0;
    err     = 1'b0;
    case (state_q)
      ST_IDLE:   if (run) state_d = ST_INIT;
      ST_INIT: begin
        ctrl[C_CLR] = 1'b1;
        state_d     = ST_F_ADDR;
      end
      ST_F_ADDR: begin
        ctrl[C_ADDR_PC] = 1'b1;
        ctrl[C_MAR_LD]  = 1'b1;
        state_d         = run ? ST_F_MEM : ST_IDLE;
      end
      ST_F_MEM: begin
        ctrl[C_ADDR_PC] = 1'b1;
        ctrl[C_MAR_LD]  = 1'b1;
        mem_req         = 1'b1;
        if (mem_ready)    state_d = ST_DECODE;
        else if (wd_fire) state_d = ST_TRAP;
      end
      ST_DECODE: begin
        ctrl[C_PC_INC] = 1'b1;
        ctrl[C_IR_LD]  = 1'b1;
        state_d        = op_illegal ? ST_TRAP : op_dispatch;
      end
      ST_X_INC: begin
        ctrl[C_ACC_INC] = 1'b1;
        state_d         = ST_F_ADDR;
      end
      ST_X_CLR: begin
        ctrl[C_ACC_CLR] = 1'b1;
        state_d         = ST_F_ADDR;
      end
      ST_X_JMP: begin
        ctrl[C_PC_LD] = 1'b1;
        state_d       = ST_F_ADDR;
      end
      ST_X_JZ:   state_d = ST_F_ADDR;
      ST_HALT: begin
        halted = 1'b1;
        if (!run) state_d = ST_IDLE;
      end
      ST_L_ADDR: begin
        ctrl[C_MAR_LD] = 1'b1;
        state_d        = ST_L_MEM;
      end
      ST_L_MEM: begin
        ctrl[C_MAR_LD] = 1'b1;
        mem_req        = 1'b1;
        if (mem_ready)    state_d = ST_L_LOAD;
        else if (wd_fire) state_d = ST_TRAP;
      end
      ST_L_LOAD: begin
        ctrl[C_ACC_MDO] = 1'b1;
        ctrl[C_ACC_LD]  = 1'b1;
        state_d         = ST_F_ADDR;
      end
      ST_S_ADDR: begin
        ctrl[C_MAR_LD] = 1'b1;
        state_d        = ST_S_WR;
      end
      ST_S_WR: begin
        ctrl[C_MAR_LD] = 1'b1;
        ctrl[C_MEM_WR] = 1'b1;
        mem_req        = 1'b1;
        if (mem_ready)    state_d = ST_F_ADDR;
        else if (wd_fire) state_d = ST_TRAP;
      end
      ST_A_ADDR: begin
        ctrl[C_MAR_LD] = 1'b1;
        state_d        = ST_A_MEM;
      end
      ST_A_MEM: begin
        ctrl[C_MAR_LD] = 1'b1;
        mem_req        = 1'b1;
        if (mem_ready)    state_d = ST_A_BUF;
        else if (wd_fire) state_d = ST_TRAP;
      end
      ST_A_BUF: begin
        ctrl[C_BUF_LD] = 1'b1;
        state_d        = ST_A_ACC;
      end
      ST_A_ACC: begin
        ctrl[C_ACC_LD] = 1'b1;
        state_d        = ST_F_ADDR;
      end
      ST_TRAP: begin
        halted  = 1'b1;
        err     = 1'b1;
        state_d = ST_TRAP;
      end
      default:   state_d = ST_TRAP;
    endcase
    // Memory states are never adjacent, so leaving one always clears the count.
    if (mem_req && !mem_ready) wd_d = wd_q + 1'b1;
  end

endmodule

// File: tb/tb_trisc_ctrl_fsm.sv
// Scoreboard bench for trisc_ctrl_fsm: each step queues its stimulus with the
// outputs expected after the following rising edge.
module tb_trisc_ctrl_fsm;

  logic        SysClock = 1'b0;
  logic        Reset = 1'b0;
  logic        run = 1'b0;
  logic        acc_zero = 1'b0;
  logic        mem_ready = 1'b1;
  logic [3:0]  opcode = 4'd0;
  logic [14:0] ctrl;
  logic        mem_req, halted, err;
  logic [17:0] obs;

  int nchk = 0;
  int nerr = 0;

  // Expected {err, halted, mem_req, ctrl[14:0]} per state
  localparam logic [17:0] E_IDLE  = 18'h00000;
  localparam logic [17:0] E_INIT  = 18'h00001;
  localparam logic [17:0] E_FADDR = 18'h00018;
  localparam logic [17:0] E_FMEM  = 18'h08018;
  localparam logic [17:0] E_DEC   = 18'h00084;
  localparam logic [17:0] E_INC   = 18'h00200;
  localparam logic [17:0] E_CLR   = 18'h00100;
  localparam logic [17:0] E_JMP   = 18'h00002;
  localparam logic [17:0] E_NOP   = 18'h00000;
  localparam logic [17:0] E_HALT  = 18'h10000;
  localparam logic [17:0] E_TRAP  = 18'h30000;
  localparam logic [17:0] E_MAR   = 18'h00010;
  localparam logic [17:0] E_RMEM  = 18'h08010;
  localparam logic [17:0] E_LLOAD = 18'h00C00;
  localparam logic [17:0] E_SWR   = 18'h08030;
  localparam logic [17:0] E_ABUF  = 18'h04000;
  localparam logic [17:0] E_AACC  = 18'h00800;

  localparam logic [3:0] O_INC = 4'd0, O_CLR = 4'd1, O_JMP = 4'd2, O_LDA = 4'd3;
  localparam logic [3:0] O_STA = 4'd4, O_ADD = 4'd5, O_HLT = 4'd6, O_JZ = 4'd7;
  localparam logic [3:0] O_BAD = 4'd12;

  typedef struct {
    logic       r;
    logic       m;
    logic       z;
    logic [3:0] o;
    logic [17:0] e;
  } step_t;

  step_t sb[$];

  trisc_ctrl_fsm #(.OPW(4), .WAIT_MAX(15)) dut (
    .SysClock  (SysClock),
    .Reset     (Reset),
    .run       (run),
    .opcode    (opcode),
    .acc_zero  (acc_zero),
    .mem_ready (mem_ready),
    .ctrl      (ctrl),
    .mem_req   (mem_req),
    .halted    (halted),
    .err       (err)
  );

  assign obs = {err, halted, mem_req, ctrl};

  always #5 SysClock = ~SysClock;

  task automatic sched(input logic r, input logic m, input logic z,
                       input logic [3:0] o, input logic [17:0] e);
    step_t s;
    s.r = r; s.m = m; s.z = z; s.o = o; s.e = e;
    sb.push_back(s);
  endtask

  task automatic apply_reset;
    run = 1'b0; mem_ready = 1'b1; acc_zero = 1'b0;
    Reset = 1'b1;
    @(posedge SysClock); #1;
    Reset = 1'b0;
  endtask

  // Queue the INIT/F_ADDR/F_MEM/DECODE prefix of a run from IDLE.
  task automatic sched_start(input logic [3:0] o);
    sched(1, 1, 0, o, E_INIT);
    sched(1, 1, 0, o, E_FADDR);
    sched(1, 1, 0, o, E_FMEM);
    sched(1, 1, 0, o, E_DEC);
  endtask

  task automatic test_reset;
    step_t s;
    int i = 0;
    Reset = 1'b0; #2; Reset = 1'b1; #1;
    nchk++;
    if (obs !== E_IDLE) begin
      nerr++; $display("FAIL reset_async: got %h want %h", obs, E_IDLE);
    end
    @(posedge SysClock); #1; Reset = 1'b0;
    sched(0, 1, 0, O_INC, E_IDLE);
    sched(0, 1, 0, O_INC, E_IDLE);
    sched(1, 1, 0, O_INC, E_INIT);
    sched(0, 1, 0, O_INC, E_FADDR);
    sched(0, 1, 0, O_INC, E_IDLE);
    while (sb.size() != 0) begin
      s = sb.pop_front();
      run = s.r; mem_ready = s.m; acc_zero = s.z; opcode = s.o;
      @(posedge SysClock); #1;
      nchk++;
      if (obs !== s.e) begin
        nerr++; $display("FAIL reset step %0d: got %h want %h", i, obs, s.e);
      end
      i++;
    end
  endtask

  task automatic test_inc;
    step_t s;
    int i = 0;
    apply_reset();
    sched(1, 1, 0, O_INC, E_INIT);
    sched(1, 1, 0, O_INC, E_FADDR);
    for (int k = 0; k < 4; k++) begin
      sched(1, 1, 0, O_INC, E_FMEM);
      sched(1, 1, 0, O_INC, E_DEC);
      sched(1, 1, 0, O_INC, E_INC);
      sched(1, 1, 0, O_INC, E_FADDR);
    end
    sched(0, 1, 0, O_INC, E_IDLE);
    while (sb.size() != 0) begin
      s = sb.pop_front();
      run = s.r; mem_ready = s.m; acc_zero = s.z; opcode = s.o;
      @(posedge SysClock); #1;
      nchk++;
      if (obs !== s.e) begin
        nerr++; $display("FAIL inc step %0d: got %h want %h", i, obs, s.e);
      end
      i++;
    end
  endtask

  task automatic test_add_wait;
    step_t s;
    int i = 0;
    apply_reset();
    sched_start(O_ADD);
    sched(1, 1, 0, O_ADD, E_MAR);
    sched(1, 1, 0, O_ADD, E_RMEM);
    sched(1, 0, 0, O_ADD, E_RMEM);
    sched(1, 0, 0, O_ADD, E_RMEM);
    sched(1, 0, 0, O_ADD, E_RMEM);
    sched(1, 1, 0, O_ADD, E_ABUF);
    sched(1, 1, 0, O_ADD, E_AACC);
    sched(1, 1, 0, O_ADD, E_FADDR);
    sched(0, 1, 0, O_ADD, E_IDLE);
    while (sb.size() != 0) begin
      s = sb.pop_front();
      run = s.r; mem_ready = s.m; acc_zero = s.z; opcode = s.o;
      @(posedge SysClock); #1;
      nchk++;
      if (obs !== s.e) begin
        nerr++; $display("FAIL add step %0d: got %h want %h", i, obs, s.e);
      end
      i++;
    end
  endtask

  task automatic test_back_to_back;
    step_t s;
    int i = 0;
    apply_reset();
    sched_start(O_LDA);
    sched(1, 1, 0, O_LDA, E_MAR);
    sched(1, 1, 0, O_LDA, E_RMEM);
    sched(1, 1, 0, O_LDA, E_LLOAD);
    sched(1, 1, 0, O_LDA, E_FADDR);
    sched(1, 1, 0, O_STA, E_FMEM);
    sched(1, 1, 0, O_STA, E_DEC);
    sched(1, 1, 0, O_STA, E_MAR);
    sched(1, 1, 0, O_STA, E_SWR);
    sched(1, 1, 0, O_STA, E_FADDR);
    sched(1, 1, 0, O_CLR, E_FMEM);
    sched(1, 1, 0, O_CLR, E_DEC);
    sched(1, 1, 0, O_CLR, E_CLR);
    sched(1, 1, 0, O_JMP, E_FADDR);
    sched(1, 1, 0, O_JMP, E_FMEM);
    sched(1, 1, 0, O_JMP, E_DEC);
    sched(1, 1, 0, O_JMP, E_JMP);
    sched(1, 1, 0, O_JMP, E_FADDR);
    sched(0, 1, 0, O_JMP, E_IDLE);
    while (sb.size() != 0) begin
      s = sb.pop_front();
      run = s.r; mem_ready = s.m; acc_zero = s.z; opcode = s.o;
      @(posedge SysClock); #1;
      nchk++;
      if (obs !== s.e) begin
        nerr++; $display("FAIL b2b step %0d: got %h want %h", i, obs, s.e);
      end
      i++;
    end
  endtask

  task automatic test_jz;
    step_t s;
    int i = 0;
    apply_reset();
    sched(1, 1, 1, O_JZ, E_INIT);
    sched(1, 1, 1, O_JZ, E_FADDR);
    sched(1, 1, 1, O_JZ, E_FMEM);
    sched(1, 1, 1, O_JZ, E_DEC);
`ifdef TRISC_JZ_EN
    sched(1, 1, 1, O_JZ, E_JMP);
    sched(1, 1, 1, O_JZ, E_FADDR);
    sched(1, 1, 0, O_JZ, E_FMEM);
    sched(1, 1, 0, O_JZ, E_DEC);
    sched(1, 1, 0, O_JZ, E_NOP);
    sched(1, 1, 0, O_JZ, E_FADDR);
    sched(0, 1, 0, O_JZ, E_IDLE);
`else
    sched(1, 1, 1, O_JZ, E_TRAP);
    sched(0, 1, 1, O_JZ, E_TRAP);
`endif
    while (sb.size() != 0) begin
      s = sb.pop_front();
      run = s.r; mem_ready = s.m; acc_zero = s.z; opcode = s.o;
      @(posedge SysClock); #1;
      nchk++;
      if (obs !== s.e) begin
        nerr++; $display("FAIL jz step %0d: got %h want %h", i, obs, s.e);
      end
      i++;
    end
  endtask

  task automatic test_hlt_trap;
    step_t s;
    int i = 0;
    apply_reset();
    sched_start(O_HLT);
    sched(1, 1, 0, O_HLT, E_HALT);
    sched(1, 1, 0, O_HLT, E_HALT);
    sched(1, 1, 0, O_HLT, E_HALT);
    sched(0, 1, 0, O_HLT, E_IDLE);
    sched_start(O_BAD);
    sched(1, 1, 0, O_BAD, E_TRAP);
    sched(0, 1, 0, O_BAD, E_TRAP);
    sched(1, 1, 0, O_INC, E_TRAP);
    sched(1, 1, 0, O_INC, E_TRAP);
    while (sb.size() != 0) begin
      s = sb.pop_front();
      run = s.r; mem_ready = s.m; acc_zero = s.z; opcode = s.o;
      @(posedge SysClock); #1;
      nchk++;
      if (obs !== s.e) begin
        nerr++; $display("FAIL hlt_trap step %0d: got %h want %h", i, obs, s.e);
      end
      i++;
    end
    Reset = 1'b1; #1;
    nchk++;
    if (obs !== E_IDLE) begin
      nerr++; $display("FAIL trap_reset_clear: got %h want %h", obs, E_IDLE);
    end
    @(posedge SysClock); #1; Reset = 1'b0;
  endtask

  task automatic test_watchdog;
    step_t s;
    int i = 0;
    apply_reset();
    sched(1, 1, 0, O_STA, E_INIT);
    sched(1, 1, 0, O_STA, E_FADDR);
    // Two stores completing on the 15th S_WR cycle, then one that times out
    for (int rep = 0; rep < 3; rep++) begin
      sched(1, 1, 0, O_STA, E_FMEM);
      sched(1, 1, 0, O_STA, E_DEC);
      sched(1, 1, 0, O_STA, E_MAR);
      sched(1, 1, 0, O_STA, E_SWR);
      for (int k = 0; k < 14; k++) sched(1, 0, 0, O_STA, E_SWR);
      if (rep < 2) sched(1, 1, 0, O_STA, E_FADDR);
      else         sched(1, 0, 0, O_STA, E_TRAP);
    end
    sched(0, 1, 0, O_STA, E_TRAP);
    while (sb.size() != 0) begin
      s = sb.pop_front();
      run = s.r; mem_ready = s.m; acc_zero = s.z; opcode = s.o;
      @(posedge SysClock); #1;
      nchk++;
      if (obs !== s.e) begin
        nerr++; $display("FAIL watchdog step %0d: got %h want %h", i, obs, s.e);
      end
      i++;
    end
  endtask

  task automatic test_reset_in_write;
    step_t s;
    int i = 0;
    apply_reset();
    sched_start(O_STA);
    sched(1, 1, 0, O_STA, E_MAR);
    sched(1, 1, 0, O_STA, E_SWR);
    sched(1, 0, 0, O_STA, E_SWR);
    sched(1, 0, 0, O_STA, E_SWR);
    while (sb.size() != 0) begin
      s = sb.pop_front();
      run = s.r; mem_ready = s.m; acc_zero = s.z; opcode = s.o;
      @(posedge SysClock); #1;
      nchk++;
      if (obs !== s.e) begin
        nerr++; $display("FAIL rst_wr step %0d: got %h want %h", i, obs, s.e);
      end
      i++;
    end
    #2; Reset = 1'b1; #1;
    nchk++;
    if (obs !== E_IDLE) begin
      nerr++; $display("FAIL rst_wr_async: got %h want %h", obs, E_IDLE);
    end
    @(posedge SysClock); #1;
    Reset = 1'b0; mem_ready = 1'b1;
    sched(0, 1, 0, O_STA, E_IDLE);
    sched(1, 1, 0, O_STA, E_INIT);
    sched(1, 1, 0, O_STA, E_FADDR);
    sched(0, 1, 0, O_STA, E_IDLE);
    i = 0;
    while (sb.size() != 0) begin
      s = sb.pop_front();
      run = s.r; mem_ready = s.m; acc_zero = s.z; opcode = s.o;
      @(posedge SysClock); #1;
      nchk++;
      if (obs !== s.e) begin
        nerr++; $display("FAIL rst_wr_after step %0d: got %h want %h", i, obs, s.e);
      end
      i++;
    end
  endtask

  initial begin
    test_reset();
    test_inc();
    test_add_wait();
    test_back_to_back();
    test_jz();
    test_hlt_trap();
    test_watchdog();
    test_reset_in_write();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
